// File: rtl/int_mul_add.sv
// int_mul_add: sequential shift-add multiply-accumulate, product = A*B + C.
// It is the inverse of the integer divider: feeding it the divider's quotient,
// divisor and remainder rebuilds the dividend. It uses the same start/ready
// handshake as the divider, and a run always takes exactly WIDTH cycles.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_i            synchronous reset, active-high, has priority over start_i
//   start_i          request, accepted only on an edge where ready_o=1
//   multiplicand_i   operand A (divider quotient when checking)
//   multiplier_i     operand B (divider divisor when checking)
//   addend_i         operand C (divider remainder when checking)
//   product_o        registered result A*B+C (2*WIDTH bits)
//   fits_o           1 when the upper WIDTH bits of product_o are zero
//   ready_o          1 = idle and product_o/fits_o valid, 0 = busy
//
// state | meaning
// IDLE  | waiting for start_i, result registers hold the last result
// BUSY  | one shift-add iteration per cycle, WIDTH iterations in total
module int_mul_add #(
  parameter int WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  input  logic [WIDTH-1:0]     addend_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 fits_o,
  output logic                 ready_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  product_q;
  logic                fits_q;
  logic                ready_q;

  // Accumulator value after the current iteration; the final iteration's add
  // must be included in the result, so completion uses this, not acc_q.
  logic [2*WIDTH-1:0]  acc_d;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      fits_q    <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, multiplicand_i};
            mplier_q <= multiplier_i;
            acc_q    <= {{WIDTH{1'b0}}, addend_i};
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          // No early exit on mplier_q==0: latency is fixed at WIDTH cycles.
          if (cnt_q == CNT_LAST) begin
            product_q <= acc_d;
            fits_q    <= (acc_d[2*WIDTH-1:WIDTH] == '0);
            ready_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign product_o = product_q;
  assign fits_o    = fits_q;
  assign ready_o   = ready_q;

endmodule

// File: doc/int_mul_add.md
Name: int_mul_add

Overview:
- Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
- Inverse of the integer divider. Fed the divider's quotient, divisor and remainder, it rebuilds the dividend.
- Used as an in-system and bench-side checker for the divider, and as a general W-bit multiplier.
- Uses the same start/ready handshake as the divider.

Parameters:
width  4  operand width W in bits; must be >= 2; product is 2W bits

Ports:
clk           input   1     rising-edge clock
rst           input   1     synchronous reset, active-high
start         input   1     request; accepted only on an edge where ready=1
multiplicand  input   W     operand A (divider quotient when checking)
multiplier    input   W     operand B (divider divisor when checking)
addend        input   W     operand C (divider remainder when checking)
product       output  2W    registered result A*B+C
fits          output  1     1 when product[2W-1:W]==0, i.e. result is representable in W bits
ready         output  1     1 = idle and product/fits valid; 0 = busy

Behaviour:
- Reset, sampled at clk edge with rst=1: state=IDLE, ready=1, product=0, fits=1, internal accumulator, shift registers and counter cleared. rst has priority over start.
- States: IDLE and BUSY.
- IDLE:
  - ready=1.
  - On an edge with start=1:
    - latch A into a 2W-bit mcand register (zero-extended);
    - latch B into a W-bit mplier register;
    - acc <= {W'b0, C};
    - cnt <= 0;
    - go to BUSY; ready drops to 0 after this edge.
- BUSY, one iteration per edge:
  - if mplier[0], acc <= acc + mcand (2W-bit add, cannot overflow);
  - mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1.
  - On the edge where cnt==W-1 (the W-th iteration):
    - product <= final acc (including this iteration's add);
    - fits <= (upper W bits of final acc == 0);
    - ready <= 1; state <= IDLE.
- Latency: start accepted at edge t, so ready=0 for edges t+1 .. t+W-1, and ready=1 with a valid product after edge t+W (exactly W cycles).
- product and fits hold their previous values throughout BUSY; they change only at completion or reset.
- start while BUSY is ignored. Operand changes during BUSY have no effect, because operands are latched at acceptance.
- start held high continuously: a new operation is accepted on the first edge after ready returns to 1, so each result is visible for at least one full cycle.
- Early termination when mplier becomes 0 is not permitted; latency is always exactly W.
- Range: max result (2^W-1)^2 + (2^W-1) < 2^(2W), so there is no overflow flag.
- rst=1 mid-operation: at that edge, abort, return to IDLE with ready=1, product=0, fits=1. A start on the same edge is discarded.
- Counter width: $clog2(width) bits, minimum 1.

Test Plan:
1. Reset (width=4): rst=1 for 10 cycles -> ready=1, product=0, fits=1. Release rst, idle 5 cycles -> outputs unchanged.
2. A=6, B=2, C=1, one-cycle start pulse -> ready=0 for exactly 4 cycles, then product=13 (0x0D), fits=1. product held until the next accepted start.
3. A=15, B=15, C=14 -> product=239 (0xEF), fits=0. Also A=0, B=9, C=0 -> product=0, fits=1. Also A=5, B=0, C=3 -> product=3, fits=1.
4. Start A=3, B=3, C=0; two cycles later pulse start with A=15, B=15, C=15 -> second request ignored, product=9. ready=1 exactly 4 cycles after the first accept.
5. Start A=7, B=7, C=0; assert rst with start=1 on the 2nd busy cycle -> after that edge ready=1, product=0, fits=1. A subsequent start for A=2, B=3, C=1 yields 7.
6. Divider round-trip:
   - instantiate the divider and int_mul_add with width=4;
   - for every dividend 0..15 and divisor 1..15, run the divider, then feed quotient/divisor/remainder here;
   - require product == dividend and fits=1 for all 240 cases;
   - for divisor=0, require the divider's err=1 and skip the check.
